pc_fetch_unit: RTL

Program-counter register and instruction-fetch sequencer for the single-cycle core. Holds the architectural PC and drives it to the next-PC computation and to instruction memory. Presents the fetched instruction to decode through a valid/ready handshake. Commits the next-PC value, sequential or branch target, when decode accepts the instruction. This block consumes the next-PC datapath's output and closes the PC loop.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/pc_fetch_unit.sv | 83 ++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the core's fetch path.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    ERROR = 2'd2
  } fetch_state_t;

  localparam int         INSTR_BYTES = 4;
  localparam logic [1:0] ALIGN_MASK  = 2'(INSTR_BYTES - 1);

  function automatic logic is_aligned(input logic [1:0] lsbs);
    return (lsbs & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_unit.sv
// Architectural PC register and fetch sequencer; hands fetched instructions
// to decode over valid/ready and commits NextPC when decode accepts.
//
//   state | meaning
//   FETCH | request outstanding at CurrentPC, waiting for imem_ack
//   HOLD  | Instruction valid, waiting for decode to accept (commit)
//   ERROR | a commit saw a misaligned NextPC; parked until Reset
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [ADDR_W-1:0]  NextPC,
  output logic [ADDR_W-1:0]  CurrentPC,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] Instruction,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               pc_misaligned,
  output logic [63:0]        retired_count
);

  fetch_state_t state, state_nxt;
  logic         commit;
  logic         commit_ok;
  logic         capture;

  assign commit    = (state == HOLD) && instr_ready;
  assign commit_ok = commit && is_aligned(NextPC[1:0]);
  // ack only counts while a request is actually outstanding
  assign capture   = (state == FETCH) && imem_ack;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (capture) state_nxt = HOLD;
      HOLD:    if (commit)  state_nxt = commit_ok ? FETCH : ERROR;
      ERROR:   state_nxt = ERROR;
      default: state_nxt = ERROR;
    endcase
  end

  always_comb begin
    imem_req      = 1'b0;
    instr_valid   = 1'b0;
    pc_misaligned = 1'b0;
    case (state)
      FETCH:   imem_req      = 1'b1;
      HOLD:    instr_valid   = 1'b1;
      ERROR:   pc_misaligned = 1'b1;
      default: pc_misaligned = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      CurrentPC     <= RESET_PC;
      Instruction   <= '0;
      retired_count <= '0;
    end else begin
      if (capture) Instruction <= imem_rdata;
      if (commit_ok) begin
        CurrentPC     <= NextPC;
        retired_count <= retired_count + 64'd1;
      end
    end
  end

  assign imem_addr = CurrentPC;

endmodule
